ahb_arbiter_2m: RTL and testbench

Two-master AHB-Lite bus arbiter that shares the existing 2-slave AHB-Lite interconnect between two requesters. It replaces the interconnect's tied-off `hmaster`, `hmaster_data` and `hmastlock_s` with live, registered values. It decides bus ownership by round-robin, holds ownership across fixed-length bursts and locked sequences, and parks on a default master when idle. It sits beside the address/data mux; the mux uses `hmaster` to pick address-phase signals and `hmaster_data` to pick write data.

---
 rtl/ahb_arb_pkg.sv | 30 +++
 rtl/ahb_burst_counter.sv | 29 ++
 rtl/ahb_arbiter_2m.sv | 73 +++++++
 tb/tb_ahb_arbiter_2m.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite encodings and helpers for the bus arbiter and its burst counter.
package ahb_arb_pkg;

  localparam int MASTER_IDX_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Beats remaining after the NONSEQ beat; undefined-length INCR is treated as unprotected.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   burst_beats = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:   burst_beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
      default:                      burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_counter.sv
// Tracks how many beats of a fixed-length burst the address-phase owner still has to issue.
module ahb_burst_counter
  import ahb_arb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  output logic [3:0] beats_left
);

  // IDLE clears the count so an early-terminated burst frees the bus; BUSY holds it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      beats_left <= 4'd0;
    end else if (HREADY) begin
      case (HTRANS)
        HTRANS_NONSEQ: beats_left <= burst_beats(HBURST);
        HTRANS_SEQ: begin
          if (beats_left != 4'd0) beats_left <= beats_left - 4'd1;
        end
        HTRANS_IDLE:   beats_left <= 4'd0;
        default:       beats_left <= beats_left;
      endcase
    end
  end

endmodule

// File: rtl/ahb_arbiter_2m.sv
// Two-master round-robin AHB-Lite arbiter with burst/lock hold, parking and registered owner pipeline.
module ahb_arbiter_2m
  import ahb_arb_pkg::*;
#(
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [1:0]              hbusreq,
  input  logic [1:0]              hlock,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HBURST,
  input  logic                    HREADY,
  output logic [1:0]              hgrant,
  output logic [MASTER_IDX_W-1:0] hmaster,
  output logic [MASTER_IDX_W-1:0] hmaster_data,
  output logic                    hmastlock
);

  localparam logic DEF_IDX = (DEFAULT_MASTER != 0);

  logic [3:0] beats_left;
  logic       grant_idx;
  logic       last_idx;
  logic       winner;
  logic       rearb_ok;

  ahb_burst_counter u_cnt (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADY     (HREADY),
    .HTRANS     (HTRANS),
    .HBURST     (HBURST),
    .beats_left (beats_left)
  );

  assign grant_idx = hgrant[1];
  assign rearb_ok  = HREADY && (beats_left < 4'd2) && !hlock[grant_idx];

  always_comb begin
    winner = DEF_IDX;
    case (hbusreq)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_idx;
      default: winner = DEF_IDX;
    endcase
  end

  // Parking on the default master is not a real grant, so it leaves the round-robin pointer alone.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hgrant   <= DEF_IDX ? 2'b10 : 2'b01;
      last_idx <= DEF_IDX;
    end else if (rearb_ok) begin
      hgrant <= winner ? 2'b10 : 2'b01;
      if (hbusreq != 2'b00) last_idx <= winner;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hmaster      <= MASTER_IDX_W'(DEF_IDX);
      hmaster_data <= MASTER_IDX_W'(DEF_IDX);
      hmastlock    <= 1'b0;
    end else if (HREADY) begin
      hmaster      <= MASTER_IDX_W'(grant_idx);
      hmaster_data <= hmaster;
      hmastlock    <= hlock[grant_idx];
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Self-checking bench for ahb_arbiter_2m: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_ahb_arbiter_2m;

  localparam int DEF = 0;

  logic       HCLK;
  logic       HRESET;
  logic [1:0] hbusreq;
  logic [1:0] hlock;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] hgrant;
  logic [3:0] hmaster;
  logic [3:0] hmaster_data;
  logic       hmastlock;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  typedef struct {
    int grant;
    int master;
    int data;
    int mlock;
    int beats;
    int last;
  } model_t;

  model_t m;
  int burst_len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  ahb_arbiter_2m #(.DEFAULT_MASTER(DEF)) u_dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .HTRANS       (HTRANS),
    .HBURST       (HBURST),
    .HREADY       (HREADY),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic model_t reset_model();
    model_t r;
    r.grant = DEF; r.master = DEF; r.data = DEF;
    r.mlock = 0;   r.beats = 0;    r.last = DEF;
    return r;
  endfunction

  // One accepted bus cycle: beats counted from burst length, owner pipeline shifts, then
  // the next owner is the first requester found after the last one granted.
  function automatic model_t step(model_t s, logic [1:0] req, logic [1:0] lk,
                                  logic [1:0] tr, logic [2:0] bu, logic rdy);
    model_t n = s;
    int pick = -1;
    if (!rdy) return s;
    case (tr)
      2'b10:   n.beats = burst_len[bu] - 1;
      2'b11:   n.beats = (s.beats > 0) ? s.beats - 1 : 0;
      2'b00:   n.beats = 0;
      default: n.beats = s.beats;
    endcase
    n.data  = s.master;
    n.master = s.grant;
    n.mlock = int'(lk[s.grant]);
    if (s.beats <= 1 && !lk[s.grant]) begin
      for (int k = 1; k <= 2; k++) begin
        int c = (s.last + k) % 2;
        if (pick < 0 && req[c]) pick = c;
      end
      if (pick < 0) n.grant = DEF;
      else begin
        n.grant = pick;
        n.last  = pick;
      end
    end
    return n;
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) m <= reset_model();
    else        m <= step(m, hbusreq, hlock, HTRANS, HBURST, HREADY);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (check_en && !HRESET) begin
      check_output("model_hgrant", 32'(hgrant), 32'(2'b01 << m.grant));
      check_output("model_hmaster", 32'(hmaster), 32'(m.master));
      check_output("model_hmaster_data", 32'(hmaster_data), 32'(m.data));
      check_output("model_hmastlock", 32'(hmastlock), 32'(m.mlock));
      check_output("model_beats_left", 32'(u_dut.u_cnt.beats_left), 32'(m.beats));
    end
  end

  task automatic apply_stimulus(input logic [1:0] req, input logic [1:0] lk,
                                input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lk;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    @(negedge HCLK);
  endtask

  task automatic pulse_reset();
    #2 HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin
    logic [1:0] r_req, r_lock, r_trans;
    logic [2:0] r_burst;
    logic       r_rdy;
    int         sel;

    HRESET = 1'b1;
    hbusreq = 2'b00; hlock = 2'b00; HTRANS = 2'b00; HBURST = 3'b000; HREADY = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    check_en = 1'b1;

    $display("[TB] idle after reset parks on master 0");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
      check_output("park_hgrant", 32'(hgrant), 32'd1);
      check_output("park_hmaster", 32'(hmaster), 32'd0);
      check_output("park_hmaster_data", 32'(hmaster_data), 32'd0);
      check_output("park_hmastlock", 32'(hmastlock), 32'd0);
    end

    $display("[TB] master 1 requests alone");
    apply_stimulus(2'b10, 2'b00, 2'b00, 3'b000, 1'b1);
    check_output("m1_grant_lat1", 32'(hgrant), 32'd2);
    check_output("m1_master_lat1", 32'(hmaster), 32'd0);
    apply_stimulus(2'b10, 2'b00, 2'b00, 3'b000, 1'b1);
    check_output("m1_master_lat2", 32'(hmaster), 32'd1);
    check_output("m1_data_lat2", 32'(hmaster_data), 32'd0);
    apply_stimulus(2'b10, 2'b00, 2'b00, 3'b000, 1'b1);
    check_output("m1_data_lat3", 32'(hmaster_data), 32'd1);

    $display("[TB] both request single transfers");
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(2'b11, 2'b00, 2'b10, 3'b000, 1'b1);
      check_output("rr_alternate", 32'(hgrant), (i % 2 == 0) ? 32'd2 : 32'd1);
    end

    $display("[TB] INCR8 burst holds grant");
    pulse_reset();
    apply_stimulus(2'b01, 2'b00, 2'b00, 3'b000, 1'b1);
    apply_stimulus(2'b01, 2'b00, 2'b00, 3'b000, 1'b1);
    apply_stimulus(2'b01, 2'b00, 2'b10, 3'b101, 1'b1);
    check_output("incr8_load", 32'(u_dut.u_cnt.beats_left), 32'd7);
    check_output("incr8_grant_ns", 32'(hgrant), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      apply_stimulus(2'b11, 2'b00, 2'b11, 3'b101, 1'b1);
      check_output("incr8_grant_seq", 32'(hgrant), (k < 7) ? 32'd1 : 32'd2);
      check_output("incr8_beats_seq", 32'(u_dut.u_cnt.beats_left), 32'(7 - k));
    end

    $display("[TB] locked INCR sequence");
    pulse_reset();
    apply_stimulus(2'b01, 2'b01, 2'b00, 3'b000, 1'b1);
    check_output("lock_mastlock_on", 32'(hmastlock), 32'd1);
    apply_stimulus(2'b11, 2'b01, 2'b10, 3'b001, 1'b1);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(2'b11, 2'b01, 2'b11, 3'b001, 1'b1);
      check_output("lock_grant_held", 32'(hgrant), 32'd1);
      check_output("lock_mastlock_held", 32'(hmastlock), 32'd1);
    end
    apply_stimulus(2'b11, 2'b00, 2'b11, 3'b001, 1'b1);
    check_output("lock_release_grant", 32'(hgrant), 32'd2);
    check_output("lock_release_mastlock", 32'(hmastlock), 32'd0);

    $display("[TB] wait states mid-handover, then asynchronous reset");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(2'b11, 2'b00, 2'b11, 3'b001, 1'b0);
      check_output("wait_hgrant", 32'(hgrant), 32'd2);
      check_output("wait_hmaster", 32'(hmaster), 32'd0);
      check_output("wait_hmaster_data", 32'(hmaster_data), 32'd0);
    end
    apply_stimulus(2'b11, 2'b00, 2'b10, 3'b111, 1'b1);
    check_output("resume_hmaster", 32'(hmaster), 32'd1);
    apply_stimulus(2'b11, 2'b00, 2'b11, 3'b111, 1'b1);
    check_output("burst_before_reset", 32'(u_dut.u_cnt.beats_left), 32'd14);
    #2 HRESET = 1'b1;
    #1;
    check_output("async_hgrant", 32'(hgrant), 32'd1);
    check_output("async_hmaster", 32'(hmaster), 32'd0);
    check_output("async_hmaster_data", 32'(hmaster_data), 32'd0);
    check_output("async_hmastlock", 32'(hmastlock), 32'd0);
    check_output("async_beats_left", 32'(u_dut.u_cnt.beats_left), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset();
      r_req   = 2'($urandom_range(0, 3));
      r_lock  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      sel     = $urandom_range(0, 9);
      r_trans = (sel < 2) ? 2'b00 : (sel == 2) ? 2'b01 : (sel < 5) ? 2'b10 : 2'b11;
      r_burst = 3'($urandom_range(0, 7));
      r_rdy   = ($urandom_range(0, 3) != 0);
      apply_stimulus(r_req, r_lock, r_trans, r_burst, r_rdy);
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
